// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial parity receiver.
//   rx_state_t  : receiver FSM states
//   bcnt_width  : width of the data-bit counter for a given word width
package serial_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4
  } rx_state_t;

  function automatic int bcnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/serial_parity_rx_parity_acc.sv
// parity_acc: running XOR accumulator, the receive-side twin of the serial
// parity generator.
//   clk, rst_n : clock, asynchronous active-low reset (clears parity to 0)
//   i_init     : load INIT_VAL (seed for even/odd parity); wins over i_en
//   i_en       : fold i_bit into the running parity
//   i_bit      : serial data bit
//   o_parity   : current accumulated parity
module parity_acc #(
  parameter int INIT_VAL = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_init,
  input  logic i_en,
  input  logic i_bit,
  output logic o_parity
);

  logic r_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (i_init) begin
      r_parity <= (INIT_VAL != 0);
    end else if (i_en) begin
      r_parity <= r_parity ^ i_bit;
    end
  end

  assign o_parity = r_parity;

endmodule

// File: rtl/serial_parity_rx.sv
// serial_parity_rx: deframes start / DATA_W data bits (LSB first) / parity /
// stop into parallel words, flags parity and framing errors and counts
// errored frames in a saturating counter.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_sin          : serial line, idle high
//   i_bit_en       : sample strobe; the line is consumed only when high
//   i_clr_cnt      : synchronous clear of o_err_count (beats an increment)
//   o_data_out     : last received word (held until the next frame)
//   o_data_valid   : one-cycle pulse per completed frame
//   o_parity_err   : parity mismatch for the frame flagged by o_data_valid
//   o_frame_err    : stop bit was 0 for the frame flagged by o_data_valid
//   o_busy         : receiver is not in IDLE
//   o_err_count    : number of errored frames, saturating
//   o_dbg_state    : current FSM state (rx_state_t encoding)
//
// Output protocol: there is no back-pressure. o_data_valid is high for
// exactly one clock per frame; o_data_out/o_parity_err/o_frame_err are
// valid in that clock and hold their value until the next pulse.
module serial_parity_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sin,
  input  logic              i_bit_en,
  input  logic              i_clr_cnt,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_data_valid,
  output logic              o_parity_err,
  output logic              o_frame_err,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_err_count,
  output logic [2:0]        o_dbg_state
);

  localparam int BCNT_W = bcnt_width(DATA_W);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

  rx_state_t          r_state;
  logic [DATA_W-1:0]  r_shift;
  logic [BCNT_W-1:0]  r_bcnt;
  logic               r_perr;
  logic               r_ferr;
  logic [CNT_W-1:0]   r_err_count;
  logic               w_parity;
  logic               w_acc_init;
  logic               w_acc_en;

  // Seed the accumulator on the start bit so that a correct frame leaves
  // running parity XOR received parity bit equal to 0.
  assign w_acc_init = i_bit_en && (r_state == IDLE) && !i_sin;
  assign w_acc_en   = i_bit_en && (r_state == DATA);

  parity_acc #(
    .INIT_VAL (ODD_PARITY)
  ) u_parity_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_init   (w_acc_init),
    .i_en     (w_acc_en),
    .i_bit    (i_sin),
    .o_parity (w_parity)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bcnt       <= '0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_err_count  <= '0;
      o_data_out   <= '0;
      o_data_valid <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      if (i_clr_cnt) begin
        r_err_count <= '0;
      end
      case (r_state)
        IDLE: begin
          if (i_bit_en && !i_sin) begin
            r_state <= DATA;
            r_bcnt  <= '0;
          end
        end
        DATA: begin
          if (i_bit_en) begin
            // LSB arrives first, so shifting in at the MSB lands it at bit 0.
            r_shift <= {i_sin, r_shift[DATA_W-1:1]};
            r_bcnt  <= r_bcnt + 1'b1;
            if (r_bcnt == LAST_BIT) begin
              r_state <= PARITY;
            end
          end
        end
        PARITY: begin
          if (i_bit_en) begin
            r_perr  <= w_parity ^ i_sin;
            r_state <= STOP;
          end
        end
        STOP: begin
          if (i_bit_en) begin
            r_ferr  <= ~i_sin;
            r_state <= DONE;
          end
        end
        DONE: begin
          // Output cycle: runs regardless of i_bit_en; a start bit seen
          // here is dropped because the FSM is not yet back in IDLE.
          o_data_out   <= r_shift;
          o_parity_err <= r_perr;
          o_frame_err  <= r_ferr;
          o_data_valid <= 1'b1;
          r_state      <= IDLE;
          if (!i_clr_cnt && (r_perr || r_ferr) && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state != IDLE);
  assign o_err_count = r_err_count;
  assign o_dbg_state = r_state;

endmodule

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
Downstream consumer of the serial parity stage. It deframes a serial bit stream into parallel words: start bit, DATA_W data bits LSB-first, one parity bit, stop bit. For each frame it checks the received parity bit against a running parity of the data bits and validates the stop bit. It emits one word per frame with error flags and keeps a saturating error counter for status readout.

Parameters:
DATA_W, 8, number of data bits per frame (2..16)
ODD_PARITY, 0, 0 = even parity expected, 1 = odd parity expected
CNT_W, 8, width of saturating error counter

Ports:
clk  in  1  rising-edge clock, single clock domain
rst_n  in  1  asynchronous active-low reset
sin  in  1  serial line; idle high
bit_en  in  1  sample strobe; sin is consumed only in cycles where bit_en=1
clr_cnt  in  1  synchronous clear of err_count
data_out  out  DATA_W  last received word
data_valid  out  1  one-cycle pulse, frame complete
parity_err  out  1  parity mismatch on the frame flagged by data_valid
frame_err  out  1  stop bit was 0 on the frame flagged by data_valid
busy  out  1  high while not in IDLE
err_count  out  CNT_W  frames with any error, saturating

Behaviour:
- Reset, asynchronous, rst_n=0: state IDLE; data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, err_count=0; shift register, bit counter and running parity cleared.
- Reset mid-frame discards the partial frame; no data_valid is produced for it.
- All state advances occur only on clk edges with bit_en=1. With bit_en=0, state, shift register, counter and parity all hold.
- IDLE: sin=0 with bit_en=1 is a start bit. Go to DATA, with bit counter=0 and running parity=ODD_PARITY. sin=1 stays in IDLE.
- DATA: shift sin into the MSB of the shift register (LSB-first arrival) and XOR sin into the running parity. Increment the counter. After the DATA_W-th bit, go to PARITY.
- PARITY: latch perr = running parity XOR sin. Go to STOP.
- STOP: latch ferr = ~sin. The next cycle is an output cycle that is independent of bit_en, registered one clock after the stop sample. In that cycle:
  - data_out is loaded with the shift register.
  - parity_err is loaded with perr and frame_err with ferr.
  - data_valid=1 for exactly one clock.
  - The state returns to IDLE.
- Stop-bit failure is not resynchronised: the receiver returns to IDLE and a low line is treated as a new start bit.
- Hold rules:
  - data_out, parity_err and frame_err hold until the next frame's output cycle.
  - data_valid is 0 in all other cycles.
- busy=1 in DATA, PARITY, STOP and the output cycle.
- Latency: data_valid rises one clk after the stop-bit sample edge.
- err_count:
  - Increments by 1 in the output cycle if perr|ferr; a frame with both errors counts once.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - clr_cnt=1 forces 0 and has priority over a simultaneous increment.
- A start bit presented in the output cycle is ignored, because the block is not yet in IDLE. The minimum inter-frame gap is one clock.

Decomposition:
- Package serial_rx_pkg holds:
  - the state enum rx_state_t {IDLE, DATA, PARITY, STOP, DONE};
  - a function for the bit-counter width, $clog2(DATA_W+1).
- One sub-module, parity_acc: a running XOR accumulator with clk, rst_n, init, en, bit inputs and a parity output. It mirrors the serial parity generator and can be unit-tested against it.
- The FSM, shift register and counter stay in serial_parity_rx.

Test Plan:
- Good frame, bit_en=1 every cycle, DATA_W=8, even parity:
  - Stimulus: start 0; data 8'hA5 LSB-first (1,0,1,0,0,1,0,1); parity 0; stop 1.
  - Required: data_out=8'hA5, data_valid pulse one clk after the stop sample, parity_err=0, frame_err=0, err_count=0.
- Parity error: same frame with parity bit 1 -> data_out=8'hA5, parity_err=1, frame_err=0, err_count=1.
- Framing error and back-to-back frames:
  - Stimulus: frame 8'h3C (parity 0) with stop bit 0, then line held low.
  - Required: frame_err=1, err_count increments; the low line starts a new frame; the next correct frame 8'h01 with parity 1 decodes cleanly.
- Strobe gaps: same good frame with bit_en=1 only every 4th cycle -> identical data_out, flags and error count; busy stays high throughout the frame.
- Reset mid-frame: rst_n pulsed low after the 4th data bit -> all outputs 0 immediately (asynchronous); no data_valid; a subsequent full frame decodes correctly.
- Counter saturation and clear (CNT_W=2):
  - Stimulus: 5 parity-error frames, then clr_cnt asserted in the same cycle as a 6th erroneous frame's data_valid.
  - Required: err_count goes 1, 2, 3, then stays at 3; the clear gives 0, not 1.
